icache_sa: RTL and testbench
============================

Name: icache_sa

Overview:
Parametrised set-associative instruction cache with a multi-word line refill engine, sitting between the instruction queue (fetch side) and the memory controller (word-read side).
- Generalises the direct-mapped, single-word ICache to N ways, 2^INDEX_BITS sets and 2^OFF_BITS words per line.
- Adds autonomous miss handling, round-robin replacement and whole-cache invalidation (fence.i / flush).

Parameters:
INDEX_BITS, 4, log2 of set count (default 16 sets)
OFF_BITS, 2, log2 of 32-bit words per line (default 4 words = 16 B)
WAYS, 2, associativity (1..8); WAYS=1 degenerates to direct-mapped

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rdy  in  1  global ready; low = freeze all state
req_valid  in  1  fetch request present
req_addr  in  32  byte address of instruction; bits[1:0] ignored
resp_valid  out  1  combinational: requested word present this cycle
resp_inst  out  32  instruction word, valid when resp_valid=1
busy  out  1  refill in progress
invalidate  in  1  clear all valid bits; abort any refill
mem_req  out  1  word read request to memory controller
mem_addr  out  32  word-aligned read address
mem_ack  in  1  one-cycle pulse: mem_rdata valid, request consumed
mem_rdata  in  32  returned word

Behaviour:
- Address split:
  - off = addr[OFF_BITS+1:2]
  - idx = addr[OFF_BITS+INDEX_BITS+1:OFF_BITS+2]
  - tag = addr[31:OFF_BITS+INDEX_BITS+2]
  - TAG_W = 30-OFF_BITS-INDEX_BITS
- Storage per set and way: valid bit, tag, 2^OFF_BITS data words. Per set: round-robin victim pointer, log2(WAYS) bits.
- Lookup (combinational):
  - hit = any way w with valid[idx][w] and tag[idx][w]==tag.
  - resp_valid = req_valid & hit & state==IDLE & rdy & ~rst.
  - resp_inst = data of the hit way at word off; 0 when resp_valid=0.
  - Multiple matching ways cannot occur by construction.
- FSM states: IDLE, REFILL.
  - IDLE -> REFILL when req_valid & ~hit & ~invalidate.
    - Latch line base = {req_addr[31:OFF_BITS+2], zeros}.
    - Victim = lowest-numbered invalid way in the set, else that set's RR pointer.
    - word counter cnt=0.
  - In REFILL:
    - mem_req=1 and mem_addr = base + 4*cnt; address is held stable until mem_ack.
    - Each mem_ack writes mem_rdata to victim word cnt, then cnt increments.
    - Words are fetched in order 0..2^OFF_BITS-1, one outstanding request.
  - At the ack of the last word: set valid=1 and tag for the victim; advance the RR pointer only if the victim was the pointer way; go to IDLE.
  - The line hits on the following cycle; refill miss latency is 2^OFF_BITS acks + 1 cycle.
- The requester holds req_addr stable until resp_valid. A req_addr change during REFILL does not affect the refill in flight.
- busy = (state==REFILL).
- invalidate (when rdy):
  - Clears every valid bit at the clock edge. RR pointers are kept.
  - In REFILL: aborts, state goes to IDLE and mem_req goes low next cycle. The partial line is never validated.
  - invalidate on the same edge as the last mem_ack: invalidate wins and the line stays invalid.
  - resp_valid is forced 0 in a cycle where invalidate=1.
- rdy=0: no state, array or counter changes, mem_ack is ignored, resp_valid=0, mem_req/mem_addr hold their values.
- Reset (sync): all valid=0, RR pointers=0, state=IDLE, cnt=0, mem_req=0, mem_addr=0, busy=0, resp_valid=0, resp_inst=0.
  - Reset during REFILL discards the refill immediately.
  - Data/tag arrays need not be cleared.
- mem_ack while not in REFILL is ignored.

Test Plan:
1. Cold miss, defaults:
   - Stimulus: req 0x0000_0104; acks return 0xA0,0xA1,0xA2,0xA3.
   - Required: mem_addr sequence 0x100,0x104,0x108,0x10C, busy=1 throughout, resp_valid=1 with resp_inst=0xA1 one cycle after the 4th ack.
   - Then req 0x10C -> same-cycle hit, resp_inst=0xA3.
2. Associativity/RR:
   - Stimulus: fill 0x100 then 0x200 (both set 0), then req 0x300.
   - Required: 0x300 evicts way 0 (0x100 line); 0x200 still hits; 0x104 misses again and evicts way 1.
3. Invalidate mid-refill:
   - Stimulus: miss on 0x400, assert invalidate after the 2nd ack.
   - Required: mem_req=0 next cycle, busy=0; a re-request of 0x400 misses and restarts at mem_addr 0x400.
   - Also: a previously cached 0x200 now misses.
4. Invalidate coincident with the last ack:
   - Required: line not valid; the next req misses.
5. rdy low during refill:
   - Stimulus: hold rdy=0 for 3 cycles with mem_ack pulsed.
   - Required: cnt unchanged, mem_addr unchanged, ack discarded.
   - After rdy=1: refill completes with correct data.
6. Reset mid-refill:
   - Required: next cycle mem_req=0, busy=0, resp_valid=0.
   - All prior lines miss.

Source files
------------

// File: rtl/icache_sa.sv
// Set-associative instruction cache with a multi-word line refill engine.
// Round-robin replacement per set, whole-cache invalidate, global rdy freeze.
module icache_sa #(
    parameter int INDEX_BITS = 4,
    parameter int OFF_BITS   = 2,
    parameter int WAYS       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    output logic [31:0] resp_inst,
    output logic        busy,
    input  logic        invalidate,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int SETS  = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFF_BITS;
    localparam int TAG_W = 30 - OFF_BITS - INDEX_BITS;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [OFF_BITS-1:0]   off;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  unused_addr;

    assign off = req_addr[OFF_BITS+1:2];
    assign idx = req_addr[OFF_BITS+INDEX_BITS+1:OFF_BITS+2];
    assign tag = req_addr[31:OFF_BITS+INDEX_BITS+2];
    assign unused_addr = ^req_addr[1:0];

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WW-1:0]    rr_q    [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [31:0]      data_q  [SETS][WAYS][WORDS];

    logic [TAG_W-1:0]      r_tag;
    logic [INDEX_BITS-1:0] r_idx;
    logic [WW-1:0]         r_way;
    logic [OFF_BITS-1:0]   cnt;

    logic          hit;
    logic [WW-1:0] hit_way;
    logic [WW-1:0] victim;
    logic          free;
    logic [WW-1:0] rr_next;
    logic          last;
    logic          start;
    logic          ack_ok;
    logic          fill_done;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Prefer the lowest empty way; fall back to the set's RR pointer.
    always_comb begin
        victim = rr_q[idx];
        free   = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!free && !valid_q[idx][w]) begin
                victim = WW'(w);
                free   = 1'b1;
            end
        end
    end

    assign resp_valid = req_valid & hit & (state_q == IDLE)
                      & rdy & ~rst & ~invalidate;
    assign resp_inst  = resp_valid ? data_q[idx][hit_way][off] : '0;

    assign busy     = (state_q == REFILL);
    assign mem_req  = busy;
    assign mem_addr = busy ? {r_tag, r_idx, cnt, 2'b00} : '0;

    assign last      = (cnt == OFF_BITS'(WORDS - 1));
    assign start     = (state_q == IDLE) & req_valid & ~hit & ~invalidate;
    assign ack_ok    = (state_q == REFILL) & mem_ack;
    assign fill_done = ack_ok & last & ~invalidate;
    assign rr_next   = (int'(r_way) == WAYS - 1) ? '0 : r_way + 1'b1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = REFILL;
            end
            REFILL: begin
                if (invalidate || (mem_ack && last)) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt     <= '0;
            r_tag   <= '0;
            r_idx   <= '0;
            r_way   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (rdy) begin
            state_q <= state_d;
            if (start) begin
                r_tag <= tag;
                r_idx <= idx;
                r_way <= victim;
                cnt   <= '0;
            end
            if (ack_ok) cnt <= cnt + 1'b1;
            if (invalidate) begin
                for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end else if (fill_done) begin
                valid_q[r_idx][r_way] <= 1'b1;
                if (r_way == rr_q[r_idx]) rr_q[r_idx] <= rr_next;
            end
        end
    end

    // Arrays carry no reset; validity alone gates their use.
    always_ff @(posedge clk) begin
        if (!rst && rdy && ack_ok) begin
            data_q[r_idx][r_way][cnt] <= mem_rdata;
            if (last) tag_q[r_idx][r_way] <= r_tag;
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: a scoreboard queue of expected words is
// drained by a monitor on every resp_valid; memory acks are driven inline.
module tb_icache_sa;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        busy;
    logic        invalidate;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb[$];

    icache_sa dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_inst (resp_inst),
        .busy      (busy),
        .invalidate(invalidate),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (resp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected act=%h exp=none", resp_inst);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (resp_inst !== e) begin
                    failures++;
                    $display("FAIL resp_inst act=%h exp=%h", resp_inst, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack(input logic [31:0] a, input logic [31:0] d,
                       input logic inv);
        @(negedge clk);
        chk("mem_req", {31'd0, mem_req}, 32'd1);
        chk("busy", {31'd0, busy}, 32'd1);
        chk("mem_addr", mem_addr, a);
        mem_ack    = 1'b1;
        mem_rdata  = d;
        invalidate = inv;
        step();
        mem_ack    = 1'b0;
        invalidate = 1'b0;
    endtask

    task automatic refill(input logic [31:0] base, input logic [7:0] p);
        for (int i = 0; i < 4; i++)
            ack(base + 32'(4 * i), 32'(p) + 32'(i), 1'b0);
    endtask

    task automatic wait_resp(input int n);
        bit got;
        got = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("resp_timely", {31'd0, got}, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic fetch_miss(input logic [31:0] a, input logic [31:0] base,
                              input logic [7:0] p, input logic [31:0] e);
        sb.push_back(e);
        req_valid = 1'b1;
        req_addr  = a;
        step();
        refill(base, p);
        wait_resp(1);
    endtask

    task automatic fetch_hit(input logic [31:0] a, input logic [31:0] e);
        sb.push_back(e);
        req_valid = 1'b1;
        req_addr  = a;
        wait_resp(1);
    endtask

    initial begin
        rst        = 1'b1;
        rdy        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        invalidate = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        step();
        step();
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_inst", resp_inst, 32'd0);
        step();
        rst = 1'b0;

        // Cold miss then same-line hit
        fetch_miss(32'h104, 32'h100, 8'hA0, 32'hA1);
        fetch_hit(32'h10C, 32'hA3);

        // Two ways in set 0, then RR eviction
        fetch_miss(32'h200, 32'h200, 8'hB0, 32'hB0);
        fetch_miss(32'h300, 32'h300, 8'hC0, 32'hC0);
        fetch_hit(32'h200, 32'hB0);
        fetch_hit(32'h308, 32'hC2);
        fetch_miss(32'h104, 32'h100, 8'hD0, 32'hD1);
        fetch_hit(32'h30C, 32'hC3);
        fetch_hit(32'h10C, 32'hD3);
        fetch_miss(32'h204, 32'h200, 8'hB0, 32'hB1);

        // Invalidate after the 2nd ack aborts the refill
        req_valid = 1'b1;
        req_addr  = 32'h400;
        step();
        ack(32'h400, 32'hE0, 1'b0);
        ack(32'h404, 32'hE1, 1'b0);
        invalidate = 1'b1;
        step();
        invalidate = 1'b0;
        req_valid  = 1'b0;
        @(negedge clk);
        chk("inv_mem_req", {31'd0, mem_req}, 32'd0);
        chk("inv_busy", {31'd0, busy}, 32'd0);
        step();
        fetch_miss(32'h400, 32'h400, 8'hE0, 32'hE0);
        fetch_miss(32'h208, 32'h200, 8'hB0, 32'hB2);

        // A hitting request sees no response while invalidate is high
        req_valid  = 1'b1;
        req_addr   = 32'h400;
        invalidate = 1'b1;
        @(negedge clk);
        chk("inv_resp_valid", {31'd0, resp_valid}, 32'd0);
        step();
        invalidate = 1'b0;
        req_valid  = 1'b0;

        // Invalidate coincident with the last ack
        req_valid = 1'b1;
        req_addr  = 32'h500;
        step();
        ack(32'h500, 32'hF0, 1'b0);
        ack(32'h504, 32'hF1, 1'b0);
        ack(32'h508, 32'hF2, 1'b0);
        ack(32'h50C, 32'hF3, 1'b1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("lastinv_busy", {31'd0, busy}, 32'd0);
        step();
        fetch_miss(32'h50C, 32'h500, 8'hF0, 32'hF3);

        // rdy low for 3 cycles with acks that must be discarded
        sb.push_back(32'h62);
        req_valid = 1'b1;
        req_addr  = 32'h608;
        step();
        ack(32'h600, 32'h60, 1'b0);
        ack(32'h604, 32'h61, 1'b0);
        rdy       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            chk("frz_mem_addr", mem_addr, 32'h608);
            chk("frz_mem_req", {31'd0, mem_req}, 32'd1);
            chk("frz_resp_valid", {31'd0, resp_valid}, 32'd0);
            step();
        end
        rdy     = 1'b1;
        mem_ack = 1'b0;
        ack(32'h608, 32'h62, 1'b0);
        ack(32'h60C, 32'h63, 1'b0);
        wait_resp(1);
        fetch_hit(32'h604, 32'h61);

        // Reset mid-refill
        req_valid = 1'b1;
        req_addr  = 32'h700;
        step();
        ack(32'h700, 32'h70, 1'b0);
        rst       = 1'b1;
        req_valid = 1'b0;
        step();
        rst       = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h608;
        @(negedge clk);
        chk("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_resp_valid", {31'd0, resp_valid}, 32'd0);
        sb.push_back(32'h82);
        step();
        refill(32'h600, 8'h80);
        wait_resp(1);
        fetch_miss(32'h50C, 32'h500, 8'h90, 32'h93);

        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
